// File: rtl/lock_pkg.sv
// Shared types for the lock access controller: FSM states, keypad symbol
// type, the idle symbol driven to the lock and a symbol-select helper.
package lock_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } lock_state_t;

    localparam sym_t IDLE_SYM = 2'b00;

    // Choose the symbol of the granted keypad (sel=1 -> requester 1).
    function automatic sym_t pick_sym(input logic sel, input sym_t s0, input sym_t s1);
        sym_t r;
        if (sel) begin
            r = s1;
        end else begin
            r = s0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from req;
// the "last granted" pointer only moves when the caller enables it.
module rr_arb2
    import lock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Winner selection: a lone requester wins, on contention the one not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_q) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Pointer next value: remember the winner only when a grant is actually issued.
    always_comb begin
        last_d = last_q;
        if (en && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset value makes requester 0 the favoured one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lock_access_ctrl.sv
// Access controller in front of electronic_lock: arbitrates two keypads,
// forwards the granted keypad's symbols, evaluates the unlock response,
// times the door-open strobe and enforces a lockout after repeated failures.
module lock_access_ctrl
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 8,
    parameter int CHECK_WIN      = 4,
    parameter int OPEN_CYCLES    = 20,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 100,
    parameter int IDLE_TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       req,
    input  logic [1:0]                       sym0,
    input  logic                             sym0_valid,
    input  logic [1:0]                       sym1,
    input  logic                             sym1_valid,
    input  logic                             unlock,
    output logic                             lock_b0,
    output logic                             lock_b1,
    output logic [1:0]                       gnt,
    output logic                             door_open,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic                             busy
);

    localparam int SW = $clog2(CODE_LEN + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int CW = $clog2(CHECK_WIN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    // Terminal values: a counter holding one of these hits its limit on this edge.
    localparam logic [SW-1:0] SYM_LAST_C  = SW'(CODE_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST_C = IW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] CHK_LAST_C  = CW'(CHECK_WIN - 1);
    localparam logic [TW-1:0] OPEN_LAST_C = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST_C = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] MAX_FAILS_C = FW'(MAX_FAILS);

    lock_state_t   state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          gidx_q, gidx_d;
    sym_t          lock_b_q, lock_b_d;
    logic          door_open_q, door_open_d;
    logic          locked_out_q, locked_out_d;
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] chk_cnt_q, chk_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic          arb_en_s;
    logic [1:0]    arb_gnt_s;
    logic          fail_s;
    logic [FW-1:0] fail_inc_s;
    logic          g_valid_s;
    logic          g_req_s;
    sym_t          g_sym_s;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (arb_en_s),
        .gnt (arb_gnt_s)
    );

    // Only the granted keypad is looked at; the other one is ignored entirely.
    assign g_valid_s  = gidx_q ? sym1_valid : sym0_valid;
    assign g_req_s    = req[gidx_q];
    assign g_sym_s    = pick_sym(gidx_q, sym0, sym1);
    assign fail_inc_s = (fail_cnt_q == MAX_FAILS_C) ? fail_cnt_q : (fail_cnt_q + FW'(1));

    // Next-state and next-output logic for the access FSM and its counters.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gidx_d       = gidx_q;
        lock_b_d     = IDLE_SYM;
        door_open_d  = 1'b0;
        locked_out_d = 1'b0;
        fail_cnt_d   = fail_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        tmr_d        = tmr_q;
        arb_en_s     = 1'b0;
        fail_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    arb_en_s   = 1'b1;
                    gnt_d      = arb_gnt_s;
                    gidx_d     = arb_gnt_s[1];
                    sym_cnt_d  = '0;
                    idle_cnt_d = '0;
                    state_d    = S_ENTRY;
                end else begin
                    gnt_d = 2'b00;
                end
            end
            S_ENTRY: begin
                // The final symbol beats a simultaneous request drop; any
                // valid symbol beats a simultaneous idle timeout.
                if (g_valid_s && (sym_cnt_q == SYM_LAST_C)) begin
                    lock_b_d  = g_sym_s;
                    sym_cnt_d = sym_cnt_q + SW'(1);
                    chk_cnt_d = '0;
                    state_d   = S_CHECK;
                end else if (!g_req_s) begin
                    gnt_d   = 2'b00;
                    state_d = S_IDLE;
                end else if (g_valid_s) begin
                    lock_b_d   = g_sym_s;
                    sym_cnt_d  = sym_cnt_q + SW'(1);
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST_C) begin
                    fail_s = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            S_CHECK: begin
                if (unlock) begin
                    gnt_d       = 2'b00;
                    fail_cnt_d  = '0;
                    door_open_d = 1'b1;
                    tmr_d       = '0;
                    state_d     = S_OPEN;
                end else if (chk_cnt_q == CHK_LAST_C) begin
                    fail_s = 1'b1;
                end else begin
                    chk_cnt_d = chk_cnt_q + CW'(1);
                end
            end
            S_OPEN: begin
                if (tmr_q == OPEN_LAST_C) begin
                    state_d = S_IDLE;
                end else begin
                    door_open_d = 1'b1;
                    tmr_d       = tmr_q + TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == LOCK_LAST_C) begin
                    fail_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    locked_out_d = 1'b1;
                    tmr_d        = tmr_q + TW'(1);
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        // A failed attempt either returns to IDLE or, at the limit, starts the lockout.
        if (fail_s) begin
            fail_cnt_d = fail_inc_s;
            gnt_d      = 2'b00;
            tmr_d      = '0;
            if (fail_inc_s == MAX_FAILS_C) begin
                locked_out_d = 1'b1;
                state_d      = S_LOCKOUT;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            fail_cnt_d = fail_cnt_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            gidx_q       <= 1'b0;
            lock_b_q     <= IDLE_SYM;
            door_open_q  <= 1'b0;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
            busy_q       <= 1'b0;
            sym_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            chk_cnt_q    <= '0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gidx_q       <= gidx_d;
            lock_b_q     <= lock_b_d;
            door_open_q  <= door_open_d;
            locked_out_q <= locked_out_d;
            fail_cnt_q   <= fail_cnt_d;
            busy_q       <= busy_d;
            sym_cnt_q    <= sym_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            tmr_q        <= tmr_d;
        end
    end

    assign lock_b0    = lock_b_q[0];
    assign lock_b1    = lock_b_q[1];
    assign gnt        = gnt_q;
    assign door_open  = door_open_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed-plus-random bench for lock_access_ctrl. A small transaction-level
// model (consecutive failure count, last granted requester) supplies the
// expected grants and failure counts; durations are measured by counting.
module tb_lock_access_ctrl;

    localparam int CODE_LEN       = 8;
    localparam int CHECK_WIN      = 4;
    localparam int OPEN_CYCLES    = 20;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 100;
    localparam int IDLE_TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] sym0 = 2'b00;
    logic       sym0_valid = 1'b0;
    logic [1:0] sym1 = 2'b00;
    logic       sym1_valid = 1'b0;
    logic       unlock = 1'b0;
    logic       lock_b0, lock_b1, door_open, locked_out, busy;
    logic [1:0] gnt;
    logic [1:0] fail_cnt;

    int total = 0;
    int bad   = 0;
    int m_fail = 0;   // model: consecutive failures
    int m_last = 1;   // model: requester granted last (1 => 0 favoured)

    always #5 clk = ~clk;

    lock_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sym0       (sym0),
        .sym0_valid (sym0_valid),
        .sym1       (sym1),
        .sym1_valid (sym1_valid),
        .unlock     (unlock),
        .lock_b0    (lock_b0),
        .lock_b1    (lock_b1),
        .gnt        (gnt),
        .door_open  (door_open),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .busy       (busy)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return (m_last == 0) ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    function automatic logic [1:0] onehot(input int who);
        return (who == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic check_zero(input string tag);
        chk(tag, {23'd0, gnt, lock_b1, lock_b0, door_open, locked_out, fail_cnt, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 2'b00; unlock = 1'b0;
        step();
        check_zero("reset_outputs");
        rst = 1'b1;
        m_fail = 0;
        m_last = 1;
    endtask

    // Granted keypad gets (s,v); the other keypad babbles random symbols.
    task automatic drive(input int who, input logic [1:0] s, input logic v);
        if (who == 0) begin
            sym0 = s; sym0_valid = v;
            sym1 = 2'($urandom); sym1_valid = 1'($urandom);
        end else begin
            sym1 = s; sym1_valid = v;
            sym0 = 2'($urandom); sym0_valid = 1'($urandom);
        end
    endtask

    task automatic request(input logic [1:0] r, output int who);
        req = r;
        who = pick(r);
        step();
        chk("grant", gnt, onehot(who));
        chk("busy_grant", busy, 1);
        m_last = who;
    endtask

    // Send the first n symbols of code (symbol i in bits 2i+1:2i).
    task automatic send_code(input int who, input logic [15:0] code, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int ng;
            ng = gaps ? int'($urandom_range(2, 0)) : 0;
            for (int k = 0; k < ng; k++) begin
                drive(who, 2'b00, 1'b0);
                step();
                chk("lock_b_gap", {lock_b1, lock_b0}, 0);
            end
            drive(who, code[2*i +: 2], 1'b1);
            step();
            chk("lock_b_sym", {lock_b1, lock_b0}, code[2*i +: 2]);
        end
        drive(who, 2'b00, 1'b0);
    endtask

    // Unlock asserted on CHECK sample 'at' (0..CHECK_WIN-1), or never if at<0.
    task automatic check_phase(input int at);
        bit done;
        done = 0;
        for (int k = 0; k < CHECK_WIN && !done; k++) begin
            unlock = (k == at);
            step();
            unlock = 1'b0;
            chk("lock_b_check", {lock_b1, lock_b0}, 0);
            if (k == at) begin
                done = 1;
                m_fail = 0;
                chk("door_open_rise", door_open, 1);
                chk("gnt_open", gnt, 0);
                chk("fail_cleared", fail_cnt, 0);
            end else if (k == CHECK_WIN - 1) begin
                done = 1;
                m_fail++;
                chk("fail_cnt_inc", fail_cnt, m_fail);
                chk("door_closed", door_open, 0);
                chk("gnt_after_fail", gnt, 0);
                chk("lockout_entry", locked_out, (m_fail == MAX_FAILS) ? 1 : 0);
                chk("busy_after_fail", busy, (m_fail == MAX_FAILS) ? 1 : 0);
            end else begin
                chk("gnt_held_check", gnt, onehot(m_last));
                chk("door_closed_check", door_open, 0);
            end
        end
    endtask

    task automatic measure_open();
        int cnt;
        cnt = door_open ? 1 : 0;
        for (int k = 0; k < OPEN_CYCLES + 10; k++) begin
            step();
            chk("gnt_during_open", gnt, 0);
            if (door_open) cnt++;
            else break;
        end
        chk("open_len", cnt, OPEN_CYCLES);
    endtask

    task automatic wait_lockout(input logic [1:0] r);
        int cnt;
        cnt = locked_out ? 1 : 0;
        req = r;
        for (int k = 0; k < LOCKOUT_CYCLES + 10; k++) begin
            step();
            chk("gnt_during_lockout", gnt, 0);
            if (locked_out) cnt++;
            else break;
        end
        req = 2'b00;
        chk("lockout_len", cnt, LOCKOUT_CYCLES);
        m_fail = 0;
        chk("fail_after_lockout", fail_cnt, 0);
    endtask

    // Full attempt from IDLE: grant, CODE_LEN symbols, check window.
    task automatic attempt(input logic [1:0] r, input int at);
        int who;
        request(r, who);
        send_code(who, 16'($urandom), CODE_LEN, 1'b1);
        check_phase(at);
    endtask

    initial begin
        int who;
        logic [1:0] r;

        do_reset();

        // 1: single successful attempt with fixed code, unlock on 2nd check cycle
        request(2'b01, who);
        send_code(who, 16'b10_11_10_01_11_10_11_10, CODE_LEN, 1'b0);
        check_phase(1);
        measure_open();
        req = 2'b00;
        chk("fail_after_success", fail_cnt, 0);

        // 2: contention from reset, round-robin hand-over
        do_reset();
        attempt(2'b11, int'($urandom_range(3, 0)));
        chk("first_winner", m_last, 0);
        measure_open();
        attempt(2'b11, int'($urandom_range(3, 0)));
        chk("second_winner", m_last, 1);
        measure_open();
        req = 2'b00;

        // 4A: abort after three symbols
        request(2'b01, who);
        send_code(who, 16'($urandom), 3, 1'b1);
        req = 2'b00;
        step();
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fail", fail_cnt, m_fail);

        // valid symbol on the timeout cycle wins
        request(2'b10, who);
        for (int k = 0; k < IDLE_TIMEOUT - 1; k++) begin
            drive(who, 2'b00, 1'b0);
            step();
        end
        chk("gnt_before_timeout", gnt, 2'b10);
        r = 2'($urandom);
        drive(who, r, 1'b1);
        step();
        chk("valid_beats_timeout", {lock_b1, lock_b0}, r);
        chk("gnt_after_late_sym", gnt, 2'b10);
        chk("fail_no_timeout", fail_cnt, m_fail);
        drive(who, 2'b00, 1'b0);
        req = 2'b00;
        step();
        chk("abort2_gnt", gnt, 0);

        // 4B: idle timeout is a failure
        request(2'b01, who);
        for (int k = 0; k < IDLE_TIMEOUT; k++) begin
            drive(who, 2'b00, 1'b0);
            step();
        end
        m_fail++;
        chk("timeout_fail", fail_cnt, m_fail);
        chk("timeout_gnt", gnt, 0);
        chk("timeout_busy", busy, 0);
        req = 2'b00;

        // 6: spurious unlock during entry only, attempt then fails in CHECK
        unlock = 1'b1;
        r = 2'($urandom_range(3, 1));
        request(r, who);
        send_code(who, 16'($urandom), CODE_LEN, 1'b1);
        chk("no_door_spurious", door_open, 0);
        check_phase(-1);
        req = 2'b00;

        // 3: three failures from a clean start, lockout, then success
        do_reset();
        for (int a = 0; a < MAX_FAILS; a++) begin
            attempt(2'($urandom_range(3, 1)), -1);
            req = 2'b00;
        end
        wait_lockout(2'($urandom_range(3, 1)));
        attempt(2'($urandom_range(3, 1)), 0);
        measure_open();
        req = 2'b00;

        // 5a: reset in the middle of LOCKOUT
        for (int a = 0; a < MAX_FAILS; a++) begin
            attempt(2'($urandom_range(3, 1)), -1);
            req = 2'b00;
        end
        for (int k = 0; k < 5; k++) step();
        chk("in_lockout", locked_out, 1);
        req = 2'b11;
        rst = 1'b0;
        step();
        check_zero("reset_mid_lockout");
        rst = 1'b1;
        m_fail = 0;
        m_last = 1;
        request(2'($urandom_range(3, 1)), who);
        send_code(who, 16'($urandom), CODE_LEN, 1'b1);
        check_phase(2);

        // 5b: reset in the middle of OPEN
        for (int k = 0; k < 3; k++) step();
        chk("in_open", door_open, 1);
        rst = 1'b0;
        step();
        check_zero("reset_mid_open");
        rst = 1'b1;
        m_fail = 0;
        m_last = 1;
        request(2'b11, who);
        chk("grant_after_reset", who, 0);
        req = 2'b00;
        step();
        chk("final_abort", gnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
- Access controller in front of electronic_lock. Arbitrates between two entry keypads, requester 0 (front) and requester 1 (rear), and forwards the granted keypad's 2-bit symbols onto the lock's b0/b1 inputs.
- Checks the lock's unlock response and holds the door-open strobe for a fixed time.
- Counts consecutive failed attempts and enforces a timed lockout.

Parameters:
- CODE_LEN, 8: valid symbols forwarded per attempt.
- CHECK_WIN, 4: cycles after the last symbol in which unlock must assert.
- OPEN_CYCLES, 20: cycles door_open is held after a successful attempt.
- MAX_FAILS, 3: consecutive failures that trigger lockout.
- LOCKOUT_CYCLES, 100: lockout duration.
- IDLE_TIMEOUT, 16: cycles with no valid symbol during entry before the attempt is aborted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req  in  2  per-requester access request (bit i = requester i).
- sym0  in  2  requester 0 symbol ({b1,b0}).
- sym0_valid  in  1  sym0 qualifier.
- sym1  in  2  requester 1 symbol.
- sym1_valid  in  1  sym1 qualifier.
- unlock  in  1  from electronic_lock.
- lock_b0  out  1  to electronic_lock b0.
- lock_b1  out  1  to electronic_lock b1.
- gnt  out  2  one-hot grant, 2'b00 when none.
- door_open  out  1  door actuator enable.
- locked_out  out  1  lockout active.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; gnt=0, lock_b0=lock_b1=0, door_open=0, locked_out=0, fail_cnt=0, busy=0; round-robin pointer favours requester 0.
- All outputs are registered. A symbol accepted in cycle N appears on lock_b1/lock_b0 in cycle N+1. In every other cycle lock_b1/lock_b0 = 2'b00 (idle symbol).
- IDLE:
  - If any req is set, grant per round-robin: if both requesters are set, the one not granted last wins; if only one, it wins.
  - gnt asserts the next cycle. Go to ENTRY; clear sym_cnt and idle_cnt.
- ENTRY:
  - Each cycle the granted requester's symX_valid=1: forward symX, sym_cnt++, idle_cnt=0. Otherwise idle_cnt++.
  - The non-granted requester's inputs are ignored entirely.
  - sym_cnt reaching CODE_LEN -> CHECK, clear the check counter.
  - Granted req drops before CODE_LEN -> abort. Return to IDLE, gnt=0, no failure counted.
  - idle_cnt reaching IDLE_TIMEOUT -> counts as a failure.
- CHECK:
  - gnt stays asserted; lock_b=00.
  - unlock=1 within CHECK_WIN cycles -> OPEN, fail_cnt=0.
  - Window expires -> failure.
- Failure handling: fail_cnt++. If fail_cnt then equals MAX_FAILS -> LOCKOUT; else -> IDLE with gnt=0.
- OPEN:
  - door_open=1 for exactly OPEN_CYCLES cycles; gnt=0.
  - New requests are not granted.
  - Then -> IDLE.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYCLES cycles. All req are ignored; gnt=0.
  - Then fail_cnt=0, -> IDLE.
- Round-robin pointer updates only when a grant is issued.
- unlock outside CHECK is ignored. This includes an unlock already high on entry to ENTRY or asserting mid-entry.
- Simultaneous events in one cycle:
  - Final valid symbol and req drop together: the symbol is taken and the attempt proceeds to CHECK.
  - IDLE_TIMEOUT and a valid symbol together: the valid symbol wins.
- Reset mid-operation (any state) returns to reset values in the next cycle, including clearing fail_cnt and lockout.
- All counters are saturating or explicitly cleared; none wraps.

Decomposition:
- Package lock_pkg: state enum (IDLE, ENTRY, CHECK, OPEN, LOCKOUT), IDLE_SYM=2'b00, and the symbol typedef logic [1:0].
- One sub-module, rr_arb2: 2-requester round-robin arbiter with pointer-update enable.
- Counters and the FSM stay in lock_access_ctrl.

Test Plan:
1. Single successful attempt:
   - Stimulus: req=01, 8 valid symbols 10,11,10,11,01,10,11,10; tb model pulses unlock 2 cycles after the last symbol.
   - Required: gnt=01 one cycle after req; lock_b mirrors each symbol 1 cycle later; door_open high exactly 20 cycles; fail_cnt=0.
2. Contention:
   - Stimulus: req=11 from reset; requester 0 completes an attempt; both still requesting.
   - Required: first grant is 01; next grant is 10 (round-robin); requester 1's symbols are not forwarded during grant 01.
3. Three failures:
   - Stimulus: three complete attempts, unlock never asserted.
   - Required: fail_cnt 1, 2, 3; locked_out high exactly 100 cycles; req ignored meanwhile; afterwards fail_cnt=0 and a grant succeeds.
4. Abort and timeout:
   - Stimulus A: req drops after 3 symbols.
   - Required A: gnt=0 next cycle, fail_cnt unchanged.
   - Stimulus B: grant held with no valid symbol for 16 cycles.
   - Required B: fail_cnt increments, return to IDLE.
5. Reset mid-LOCKOUT and mid-OPEN:
   - Stimulus: rst=0 for one cycle during each state.
   - Required: all outputs 0 on the next posedge; a fresh req is granted right after rst=1.
6. Spurious unlock:
   - Stimulus: unlock=1 during ENTRY only.
   - Required: no door_open; the attempt fails when the CHECK window expires.
